mem_dmem_ctrl: RTL and testbench
================================

// Module: mem_dmem_ctrl
// PURPOSE
//  MEM-stage data-memory initiator; the producer side of the MEM/WB stage register.
//  Takes the load/store held in EX/MEM and aligns the address.
//  Builds the read/write byte masks and store data, then runs a request/response handshake with the data cache.
//  Drives stall while the access is outstanding.
//  Presents rdata, bit_shift, aligned address, masks and trap to the MEM/WB register.
// PARAMETERS
//  XLEN  32  data/address width (only 32 supported)
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  valid_in       in   1     EX/MEM holds a valid instruction
//  mem_read       in   1     instruction is a load
//  mem_write      in   1     instruction is a store
//  funct3         in   3     000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr           in   32    effective address (ALU result)
//  store_data     in   32    rs2 value
//  advance        in   1     MEM/WB load enable this cycle
//  dmem_resp      in   1     cache response; one cycle per request
//  dmem_rdata     in   32    cache read data, valid with dmem_resp
//  dmem_read      out  1     read request
//  dmem_write     out  1     write request
//  dmem_addr      out  32    {addr[31:2],2'b00}
//  dmem_wmask     out  4     byte enables for write
//  dmem_wdata     out  32    store_data << (8*addr[1:0])
//  stall_out      out  1     freeze PC..EX/MEM; also becomes cur_stall for MEM/WB
//  rdata_out      out  32    raw aligned word captured from dmem_rdata
//  bit_shift      out  2     addr[1:0], used by WB for extraction
//  addr_aligned   out  32    same as dmem_addr
//  rmask_out      out  4     read byte mask (0 for non-loads)
//  wmask_out      out  4     write byte mask (0 for non-stores)
//  trap_out       out  1     misaligned access
// BEHAVIOUR
//  Masks: B/BU = 4'b0001<<addr[1:0]; H/HU = 4'b0011<<addr[1:0]; W = 4'b1111.
//  Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//   - Sets trap_out=1 and both masks 0.
//   - Issues no request; stall_out=0 (trap instruction passes straight to WB).
//  Op = valid_in & (mem_read|mem_write) & ~misaligned. Non-op instructions: stall_out=0, masks 0.
//  FSM states: IDLE, REQ, DONE.
//   - IDLE: Op seen -> REQ.
//     Registers dmem_read/dmem_write/addr/wmask/wdata, so requests go high at the edge entering REQ.
//   - REQ: hold all request outputs stable until dmem_resp sampled high.
//     On that edge: capture dmem_rdata into rdata_out (loads only), deassert requests, -> DONE.
//   - DONE: advance=1 -> IDLE; advance=0 -> stay DONE, holding rdata_out (no re-issue).
//  stall_out = Op & (state != DONE). Combinational; high in IDLE/REQ for an Op.
//  Minimum load latency: 2 cycles (IDLE + REQ).
//   - Accepted edge N; resp at N+1; DONE in N+2, where the instruction leaves if advance=1.
//  EX/MEM inputs are frozen by stall_out and must stay stable while stall_out=1.
//  Back-to-back ops: the next Op is accepted the cycle after leaving DONE (IDLE cycle).
//  dmem_resp in IDLE/DONE is ignored.
//  bit_shift, addr_aligned, rmask_out, wmask_out, trap_out are combinational from inputs.
//  Reset (mid-operation as well): state=IDLE, dmem_read=dmem_write=0.
//   - dmem_addr, dmem_wmask, dmem_wdata and rdata_out = 0.
//   - In-flight request is abandoned; a late dmem_resp after reset is ignored.
//  No flush/cancel: an issued request always completes.
// TESTING
//  LW addr=0x100, resp one cycle after request, rdata=0xDEADBEEF ->
//   dmem_read high 1 cycle, dmem_addr=0x100, stall_out 2 cycles, rdata_out=0xDEADBEEF, rmask=1111.
//  SB addr=0x203, store_data=0x000000AB ->
//   dmem_wmask=1000, dmem_wdata=0xAB000000, dmem_addr=0x200, wmask_out=1000.
//  LH addr=0x101 -> trap_out=1, no dmem_read, stall_out=0, rmask_out=0.
//  LBU addr=0x42, resp delayed 5 cycles -> requests stable 5 cycles, stall_out=1 throughout, rmask=0100, bit_shift=2.
//  Resp arrives while advance=0 for 3 cycles -> DONE held, rdata_out stable, no second request.
//  rst asserted in REQ, then stray resp -> outputs 0, IDLE, stray resp ignored; next LW works normally.

Source files
------------

// File: rtl/mem_dmem_ctrl.sv
// MEM-stage data-memory initiator: aligns the access, builds byte masks and store data,
// and runs a single-outstanding request/response handshake with the data cache.
module mem_dmem_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            advance,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            stall_out,
    output logic [XLEN-1:0] rdata_out,
    output logic [1:0]      bit_shift,
    output logic [XLEN-1:0] addr_aligned,
    output logic [3:0]      rmask_out,
    output logic [3:0]      wmask_out,
    output logic            trap_out
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t     state;
    logic [1:0] off;
    logic [3:0] size_mask;
    logic       misaligned;
    logic       is_mem;
    logic       op;

    assign off = addr[1:0];

    // Unsupported funct3 encodings fall into the word case
    always_comb begin
        size_mask  = 4'b1111;
        misaligned = (off != 2'b00);
        case (funct3)
            3'b000, 3'b100: begin
                size_mask  = 4'b0001 << off;
                misaligned = 1'b0;
            end
            3'b001, 3'b101: begin
                size_mask  = 4'b0011 << off;
                misaligned = off[0];
            end
            default: ;
        endcase
    end

    assign is_mem       = valid_in & (mem_read | mem_write);
    assign trap_out     = is_mem & misaligned;
    assign op           = is_mem & ~misaligned;
    assign rmask_out    = (op & mem_read)  ? size_mask : 4'b0000;
    assign wmask_out    = (op & mem_write) ? size_mask : 4'b0000;
    assign bit_shift    = off;
    assign addr_aligned = {addr[XLEN-1:2], 2'b00};
    assign stall_out    = op & (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr  <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            rdata_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        state      <= REQ;
                        dmem_read  <= mem_read;
                        dmem_write <= mem_write;
                        dmem_addr  <= addr_aligned;
                        dmem_wmask <= wmask_out;
                        dmem_wdata <= store_data << {off, 3'b000};
                    end
                end
                REQ: begin
                    if (dmem_resp) begin
                        if (dmem_read)
                            rdata_out <= dmem_rdata;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Result is held until MEM/WB takes it; the request is never re-issued
                    if (advance)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dmem_ctrl.sv
// Scoreboard bench for mem_dmem_ctrl: the driver pushes expected cache requests,
// a monitor pops and compares them at each request/response handshake.
module tb_mem_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write, advance, dmem_resp;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, dmem_rdata;
    logic        dmem_read, dmem_write, stall_out, trap_out;
    logic [31:0] dmem_addr, dmem_wdata, rdata_out, addr_aligned;
    logic [3:0]  dmem_wmask, rmask_out, wmask_out;
    logic [1:0]  bit_shift;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    req_t req_q[$];
    req_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_dmem_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .advance(advance), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .stall_out(stall_out),
        .rdata_out(rdata_out), .bit_shift(bit_shift), .addr_aligned(addr_aligned),
        .rmask_out(rmask_out), .wmask_out(wmask_out), .trap_out(trap_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Monitor: every handshake must match the oldest expected request
    always begin
        @(negedge clk);
        if (!rst && (dmem_read || dmem_write) && dmem_resp) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 32'd1, 32'd0);
            end else begin
                mon_e = req_q.pop_front();
                chk("dmem_addr", dmem_addr, mon_e.addr);
                chk("dmem_read", {31'd0, dmem_read}, {31'd0, mon_e.rd});
                chk("dmem_write", {31'd0, dmem_write}, {31'd0, mon_e.wr});
                chk("dmem_wmask", {28'd0, dmem_wmask}, {28'd0, mon_e.wmask});
                if (mon_e.wr) chk("dmem_wdata", dmem_wdata, mon_e.wdata);
                if (mon_e.rd) begin
                    @(negedge clk);
                    chk("rdata_out", rdata_out, mon_e.rdata);
                end
            end
        end
    end

    // One instruction through MEM: d = cycles of REQ without response, hold = DONE cycles with advance=0
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdv,
                          input int d, input int hold);
        int         nb, stalls;
        logic       mis;
        logic [7:0] m8;
        logic [3:0] mask;
        req_t       e;
        nb   = nbytes(f3);
        mis  = (a % nb) != 0;
        m8   = 8'(((1 << nb) - 1) << (a % 4));
        mask = m8[3:0];
        valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = sd; advance = 1'b0; dmem_resp = 1'b0;
        #1;
        chk("trap_out", {31'd0, trap_out}, {31'd0, mis});
        chk("rmask_out", {28'd0, rmask_out}, (rd && !mis) ? {28'd0, mask} : 32'd0);
        chk("wmask_out", {28'd0, wmask_out}, (wr && !mis) ? {28'd0, mask} : 32'd0);
        chk("bit_shift", {30'd0, bit_shift}, a % 4);
        chk("addr_aligned", addr_aligned, a & ~32'd3);
        chk("stall_idle", {31'd0, stall_out}, {31'd0, !mis});
        if (mis) begin
            @(negedge clk);
            chk("no_req_on_trap", {31'd0, dmem_read | dmem_write}, 32'd0);
            @(posedge clk); #1;
            valid_in = 1'b0;
            return;
        end
        e.addr  = a & ~32'd3;
        e.rd    = rd;
        e.wr    = wr;
        e.wmask = wr ? mask : 4'd0;
        e.wdata = sd << (8 * (a % 4));
        e.rdata = rdv;
        req_q.push_back(e);
        stalls = int'(stall_out);
        @(posedge clk); #1;
        for (int k = 0; k < d; k++) begin
            #1;
            stalls += int'(stall_out);
            chk("req_held", {dmem_read, dmem_write, dmem_wmask, 26'd0}, {rd, wr, e.wmask, 26'd0});
            @(posedge clk); #1;
        end
        dmem_resp = 1'b1; dmem_rdata = rdv;
        #1;
        stalls += int'(stall_out);
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = $urandom;
        chk("stall_cycles", stalls, d + 2);
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("done_stall", {31'd0, stall_out}, 32'd0);
            chk("done_no_req", {31'd0, dmem_read | dmem_write}, 32'd0);
            if (rd) chk("done_rdata_hold", rdata_out, rdv);
            @(posedge clk); #1;
        end
        advance = 1'b1;
        #1;
        chk("leave_stall", {31'd0, stall_out}, 32'd0);
        chk("leave_no_req", {31'd0, dmem_read | dmem_write}, 32'd0);
        @(posedge clk); #1;
        advance = 1'b0; valid_in = 1'b0;
    endtask

    task automatic reset_mid_req();
        req_t e;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_0300; advance = 1'b0; dmem_resp = 1'b0;
        e.addr = 32'h300; e.rd = 1'b1; e.wr = 1'b0; e.wmask = 4'd0; e.wdata = 32'd0; e.rdata = 32'd0;
        req_q.push_back(e);
        @(posedge clk); #1;
        chk("rst_pre_req", {31'd0, dmem_read}, 32'd1);
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(req_q.pop_back());
        chk("rst_read", {31'd0, dmem_read | dmem_write}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
        dmem_resp = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("stray_read", {31'd0, dmem_read}, 32'd0);
        chk("stray_rdata", rdata_out, 32'd0);
        chk("stray_stall", {31'd0, stall_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0; advance = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", {31'd0, dmem_read | dmem_write}, 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        chk("reset_stall", {31'd0, stall_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0);
        run_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00AB, 32'd0, 0, 0);
        run_op(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 32'd0, 0, 0);
        run_op(1'b1, 1'b0, 3'b100, 32'h42, 32'd0, 32'h1122_3344, 5, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 32'hCAFE_F00D, 0, 3);
        reset_mid_req();
        run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h5A5A_A5A5, 1, 0);

        for (int i = 0; i < 150; i++) begin
            logic       rd;
            logic [2:0] f3;
            rd = 1'($urandom % 2);
            case (rd ? $urandom % 5 : $urandom % 3)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            run_op(rd, !rd, f3, $urandom, $urandom, $urandom, int'($urandom % 6), int'($urandom % 4));
            if ($urandom % 2 == 1) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", req_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
